// File: rtl/tnet_cmd_sched_pkg.sv
// Shared types and constants for the TNET command scheduler: command payload,
// FSM states, TNET_CTRL bit positions and TNET_STATUS field positions.
package tnet_cmd_sched_pkg;

    localparam int unsigned OP_W   = 5;
    localparam int unsigned TOUT_W = 16;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DT_W   = 32;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned CTRL_EXEC   = 0;
    localparam int unsigned CTRL_OP_LSB = 1;
    localparam int unsigned CTRL_ABORT  = 31;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_AXI_PEND  = 1;
    localparam int unsigned STAT_TP_PEND   = 2;
    localparam int unsigned STAT_LAST_ERR  = 3;
    localparam int unsigned STAT_LAST_TOUT = 4;
    localparam int unsigned STAT_LAST_SRC  = 5;
    localparam int unsigned STAT_OP_LSB    = 6;
    localparam int unsigned STAT_DONE_LSB  = 16;
    localparam int unsigned STAT_DROP_LSB  = 24;

    localparam logic SRC_AXI = 1'b0;
    localparam logic SRC_TP  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] addr;
        logic [DT_W-1:0]   dt;
    } cmd_t;

endpackage

// File: rtl/tnet_cmd_sched_if.sv
// Command bus between the scheduler (master) and the network core (slave).
interface tnet_cmd_sched_if;
    import tnet_cmd_sched_pkg::*;

    logic valid;
    logic ready;
    cmd_t payload;
    logic src;
    logic done;
    logic err;

    modport master (output valid, payload, src, input ready, done, err);
    modport slave  (input valid, payload, src, output ready, done, err);
endinterface

// File: rtl/tnet_cmd_slot.sv
// One-entry command holding register; a load in the same cycle as a clear wins,
// so a capture coinciding with a serve is never lost.
module tnet_cmd_slot
    import tnet_cmd_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  cmd_t din,
    output logic full,
    output cmd_t dout
);

    logic full_q, full_d;
    cmd_t data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = din;
        end else if (clear) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/tnet_cmd_sched.sv
// Round-robin command scheduler between the AXI register path and the tProc port,
// issuing one command at a time to the TNET core and tracking completion/timeout.
module tnet_cmd_sched
    import tnet_cmd_sched_pkg::*;
(
    input  logic                ps_aclk,
    input  logic                ps_aresetn,
    input  logic [31:0]         tnet_ctrl_i,
    input  logic [31:0]         tnet_cfg_i,
    input  logic [ADDR_W-1:0]   tnet_addr_i,
    input  logic [DT_W-1:0]     axi_dt_i,
    input  logic                tp_req_i,
    input  logic [OP_W-1:0]     tp_op_i,
    input  logic [ADDR_W-1:0]   tp_addr_i,
    input  logic [DT_W-1:0]     tp_dt_i,
    output logic                tp_ack_o,
    tnet_cmd_sched_if.master    cmd,
    output logic [31:0]         tnet_status_o
);

    logic unused_bits;
    assign unused_bits = ^{tnet_ctrl_i[30:CTRL_OP_LSB+OP_W], tnet_cfg_i[31:TOUT_W]};

    state_e              state_q, state_d;
    logic                exec_prev_q;
    logic                rr_q, rr_d;
    cmd_t                cmd_q, cmd_d;
    logic                src_q, src_d;
    logic                valid_q, valid_d;
    logic [TOUT_W-1:0]   tout_q, tout_d;
    logic                last_err_q, last_err_d;
    logic                last_tout_q, last_tout_d;
    logic                last_src_q, last_src_d;
    logic [OP_W-1:0]     last_op_q, last_op_d;
    logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
    logic                tp_ack_q, tp_ack_d;
    logic [31:0]         status_q, status_d;

    logic abort, exec_rise, drop;
    logic serve_axi, serve_tp, flush;
    logic axi_load, tp_load, axi_full, tp_full;
    cmd_t axi_din, tp_din, axi_cmd, tp_cmd;

    assign abort     = tnet_ctrl_i[CTRL_ABORT];
    assign exec_rise = tnet_ctrl_i[CTRL_EXEC] & ~exec_prev_q;

    assign axi_din = '{op: tnet_ctrl_i[CTRL_OP_LSB +: OP_W], addr: tnet_addr_i, dt: axi_dt_i};
    assign tp_din  = '{op: tp_op_i, addr: tp_addr_i, dt: tp_dt_i};

    // A slot being served this cycle counts as free for capture.
    assign axi_load = exec_rise & ~abort & (~axi_full | serve_axi);
    assign drop     = exec_rise & ~abort & axi_full & ~serve_axi;
    assign tp_load  = tp_req_i & ~abort & (~tp_full | serve_tp);

    tnet_cmd_slot u_axi_slot (
        .clk   (ps_aclk),
        .rst_n (ps_aresetn),
        .load  (axi_load),
        .clear (serve_axi | flush),
        .din   (axi_din),
        .full  (axi_full),
        .dout  (axi_cmd)
    );

    tnet_cmd_slot u_tp_slot (
        .clk   (ps_aclk),
        .rst_n (ps_aresetn),
        .load  (tp_load),
        .clear (serve_tp | flush),
        .din   (tp_din),
        .full  (tp_full),
        .dout  (tp_cmd)
    );

    // Next-state and datapath for the issue/wait sequence.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cmd_d       = cmd_q;
        src_d       = src_q;
        tout_d      = tout_q;
        last_err_d  = last_err_q;
        last_tout_d = last_tout_q;
        last_src_d  = last_src_q;
        last_op_d   = last_op_q;
        done_cnt_d  = done_cnt_q;
        serve_axi   = 1'b0;
        serve_tp    = 1'b0;
        flush       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!abort && (axi_full || tp_full)) begin
                    src_d   = (axi_full && tp_full) ? rr_q : tp_full;
                    cmd_d   = (src_d == SRC_TP) ? tp_cmd : axi_cmd;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    flush      = 1'b1;
                    last_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (cmd.ready) begin
                    serve_axi  = (src_q == SRC_AXI);
                    serve_tp   = (src_q == SRC_TP);
                    rr_d       = ~src_q;
                    tout_d     = tnet_cfg_i[TOUT_W-1:0];
                    last_src_d = src_q;
                    last_op_d  = cmd_q.op;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    flush      = 1'b1;
                    last_err_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (cmd.done) begin
                    last_err_d  = cmd.err;
                    last_tout_d = 1'b0;
                    done_cnt_d  = done_cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end else if (tout_q != '0) begin
                    tout_d = tout_q - TOUT_W'(1);
                    if (tout_q == TOUT_W'(1)) begin
                        last_tout_d = 1'b1;
                        last_err_d  = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        valid_d    = (state_d == S_ISSUE);
        tp_ack_d   = tp_load;
        drop_cnt_d = (drop && drop_cnt_q != {CNT_W{1'b1}}) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
        status_d   = {drop_cnt_q, done_cnt_q, 5'd0, last_op_q, last_src_q, last_tout_q,
                      last_err_q, tp_full, axi_full, (state_q != S_IDLE)};
    end

    always_ff @(posedge ps_aclk) begin
        if (!ps_aresetn) begin
            state_q     <= S_IDLE;
            exec_prev_q <= 1'b0;
            rr_q        <= SRC_AXI;
            cmd_q       <= '0;
            src_q       <= 1'b0;
            valid_q     <= 1'b0;
            tout_q      <= '0;
            last_err_q  <= 1'b0;
            last_tout_q <= 1'b0;
            last_src_q  <= 1'b0;
            last_op_q   <= '0;
            done_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            tp_ack_q    <= 1'b0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            exec_prev_q <= tnet_ctrl_i[CTRL_EXEC];
            rr_q        <= rr_d;
            cmd_q       <= cmd_d;
            src_q       <= src_d;
            valid_q     <= valid_d;
            tout_q      <= tout_d;
            last_err_q  <= last_err_d;
            last_tout_q <= last_tout_d;
            last_src_q  <= last_src_d;
            last_op_q   <= last_op_d;
            done_cnt_q  <= done_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            tp_ack_q    <= tp_ack_d;
            status_q    <= status_d;
        end
    end

    assign cmd.valid     = valid_q;
    assign cmd.payload   = cmd_q;
    assign cmd.src       = src_q;
    assign tp_ack_o      = tp_ack_q;
    assign tnet_status_o = status_q;

endmodule

// File: tb/tb_tnet_cmd_sched.sv
// Directed bench for tnet_cmd_sched: one task per scenario with hand-computed expectations.
module tb_tnet_cmd_sched;
    import tnet_cmd_sched_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       tnet_ctrl, tnet_cfg, axi_dt, tp_dt, tnet_status;
    logic [15:0]       tnet_addr, tp_addr;
    logic              tp_req, tp_ack;
    logic [OP_W-1:0]   tp_op;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int hs_cnt = 0;

    tnet_cmd_sched_if bus ();

    tnet_cmd_sched dut (
        .ps_aclk       (clk),
        .ps_aresetn    (rst_n),
        .tnet_ctrl_i   (tnet_ctrl),
        .tnet_cfg_i    (tnet_cfg),
        .tnet_addr_i   (tnet_addr),
        .axi_dt_i      (axi_dt),
        .tp_req_i      (tp_req),
        .tp_op_i       (tp_op),
        .tp_addr_i     (tp_addr),
        .tp_dt_i       (tp_dt),
        .tp_ack_o      (tp_ack),
        .cmd           (bus),
        .tnet_status_o (tnet_status)
    );

    always #5 clk = ~clk;

    // Event monitors: tProc acks and core handshakes, sampled mid-cycle.
    always @(negedge clk) begin
        if (tp_ack === 1'b1) ack_cnt++;
        if (bus.valid === 1'b1 && bus.ready === 1'b1) hs_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tnet_ctrl = '0; tnet_cfg = '0; tnet_addr = '0; axi_dt = '0;
        tp_req = 1'b0; tp_op = '0; tp_addr = '0; tp_dt = '0;
        bus.ready = 1'b0; bus.done = 1'b0; bus.err = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
        checks++; if (bus.payload !== '0) begin errors++; $display("FAIL reset_payload got %h exp 0", bus.payload); end
        checks++; if (tp_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", tp_ack); end
        checks++; if (tnet_status !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", tnet_status); end
    endtask

    task automatic test_single_axi();
        tnet_cfg = 32'd100; bus.ready = 1'b1;
        tnet_addr = 16'h1234; axi_dt = 32'hDEAD_BEEF;
        tnet_ctrl = 32'h0000_0007;
        tick(2);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", bus.valid); end
        checks++; if (bus.payload.op !== 5'd3) begin errors++; $display("FAIL single_op got %0d exp 3", bus.payload.op); end
        checks++; if (bus.src !== 1'b0) begin errors++; $display("FAIL single_src got %b exp 0", bus.src); end
        checks++; if (bus.payload.addr !== 16'h1234 || bus.payload.dt !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_payload got %h/%h exp 1234/deadbeef", bus.payload.addr, bus.payload.dt); end
        tick();
        tick(10);
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tick();
        checks++; if (tnet_status !== 32'h0001_00C0) begin errors++; $display("FAIL single_status got %h exp 000100c0", tnet_status); end
        tnet_ctrl = '0; tick();
    endtask

    task automatic test_contention();
        int ack0, hs0;
        do_reset();
        ack0 = ack_cnt; hs0 = hs_cnt;
        tnet_cfg = '0;
        tnet_ctrl = 32'h0000_000B; tnet_addr = 16'h00A0; axi_dt = 32'h1111_1111;
        tp_req = 1'b1; tp_op = 5'd9; tp_addr = 16'h00B0; tp_dt = 32'h2222_2222;
        tick();
        checks++; if (tp_ack !== 1'b1) begin errors++; $display("FAIL cont_ack got %b exp 1", tp_ack); end
        tp_req = 1'b0;
        tick();
        checks++; if (bus.valid !== 1'b1 || bus.src !== 1'b0 || bus.payload.op !== 5'd5) begin
            errors++; $display("FAIL cont_first got v=%b src=%b op=%0d exp v=1 src=0 op=5", bus.valid, bus.src, bus.payload.op); end
        bus.ready = 1'b1; tick(); bus.ready = 1'b0;
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tick();
        checks++; if (bus.valid !== 1'b1 || bus.src !== 1'b1 || bus.payload.op !== 5'd9 || bus.payload.addr !== 16'h00B0) begin
            errors++; $display("FAIL cont_second got v=%b src=%b op=%0d addr=%h exp v=1 src=1 op=9 addr=00b0",
                               bus.valid, bus.src, bus.payload.op, bus.payload.addr); end
        bus.ready = 1'b1; tick(); bus.ready = 1'b0;
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tick(2);
        checks++; if (tnet_status !== 32'h0002_0260) begin errors++; $display("FAIL cont_status got %h exp 00020260", tnet_status); end
        checks++; if (ack_cnt - ack0 !== 1) begin errors++; $display("FAIL cont_ack_count got %0d exp 1", ack_cnt - ack0); end
        checks++; if (hs_cnt - hs0 !== 2) begin errors++; $display("FAIL cont_hs_count got %0d exp 2", hs_cnt - hs0); end
        tnet_ctrl = '0; tick();
    endtask

    task automatic test_drop();
        int hs0;
        logic [31:0] st;
        hs0 = hs_cnt;
        tnet_cfg = '0; bus.ready = 1'b1;
        tnet_ctrl = 32'h0000_0003; tick(3);
        tnet_ctrl = '0; tick();
        tnet_ctrl = 32'h0000_0005; tick();
        tnet_ctrl = '0; tick();
        tnet_ctrl = 32'h0000_0007; tick();
        tnet_ctrl = '0; tick();
        st = tnet_status;
        checks++; if (st[31:24] !== 8'd1 || st[1] !== 1'b1 || st[0] !== 1'b1) begin
            errors++; $display("FAIL drop_busy_status got %h exp drop=1 axi_pend=1 busy=1", st); end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tick();
        checks++; if (bus.valid !== 1'b1 || bus.payload.op !== 5'd2) begin
            errors++; $display("FAIL drop_second_op got v=%b op=%0d exp v=1 op=2", bus.valid, bus.payload.op); end
        tick();
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tick(4);
        st = tnet_status;
        checks++; if (hs_cnt - hs0 !== 2) begin errors++; $display("FAIL drop_hs_count got %0d exp 2", hs_cnt - hs0); end
        checks++; if (st[31:24] !== 8'd1 || st[23:16] !== 8'd4 || st[2:0] !== 3'b000 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL drop_final_status got %h v=%b exp drop=1 done=4 idle", st, bus.valid); end
        bus.ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic [31:0] st;
        tnet_cfg = 32'd5; bus.ready = 1'b1;
        tnet_ctrl = 32'h0000_0009; tick(3);
        tnet_ctrl = '0;
        tick(5);
        checks++; if (tnet_status[0] !== 1'b1) begin errors++; $display("FAIL tout_early got busy=%b exp 1", tnet_status[0]); end
        tick();
        st = tnet_status;
        checks++; if (st[0] !== 1'b0 || st[4:3] !== 2'b11 || st[23:16] !== 8'd4) begin
            errors++; $display("FAIL tout_expire got %h exp busy=0 tout/err=11 done=4", st); end

        tnet_cfg = '0;
        tnet_ctrl = 32'h0000_0009; tick(3);
        tnet_ctrl = '0; bus.ready = 1'b0;
        tick(1000);
        checks++; if (tnet_status[0] !== 1'b1 || bus.valid !== 1'b0) begin
            errors++; $display("FAIL tout_disabled got busy=%b v=%b exp busy=1 v=0", tnet_status[0], bus.valid); end
        bus.done = 1'b1; bus.err = 1'b1; tick(); bus.done = 1'b0; bus.err = 1'b0;
        tick();
        st = tnet_status;
        checks++; if (st[0] !== 1'b0 || st[4:3] !== 2'b01 || st[23:16] !== 8'd5) begin
            errors++; $display("FAIL tout_done_err got %h exp busy=0 tout/err=01 done=5", st); end
    endtask

    task automatic test_backpressure_abort();
        int unstable = 0;
        logic [31:0] st;
        do_reset();
        tnet_cfg = 32'd50;
        tnet_ctrl = 32'h0000_000D; tnet_addr = 16'h5A5A; axi_dt = 32'hCAFE_F00D;
        tp_req = 1'b1; tp_op = 5'd17; tp_addr = 16'h0777; tp_dt = 32'h0BAD_0BAD;
        tick(); tp_req = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (bus.valid !== 1'b1 || bus.src !== 1'b0 || bus.payload.op !== 5'd6 ||
                bus.payload.addr !== 16'h5A5A || bus.payload.dt !== 32'hCAFE_F00D) unstable++;
            tick();
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles exp 0", unstable); end
        tnet_ctrl = 32'h8000_000D;
        tick();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", bus.valid); end
        tp_req = 1'b1;
        tick();
        st = tnet_status;
        checks++; if (st[3:0] !== 4'b1000) begin errors++; $display("FAIL abort_status got %h exp [3:0]=1000", st); end
        tick();
        checks++; if (tp_ack !== 1'b0) begin errors++; $display("FAIL abort_no_capture got ack=%b exp 0", tp_ack); end
        tp_req = 1'b0; tnet_ctrl = '0;
        tick(3);
        checks++; if (bus.valid !== 1'b0 || tnet_status[2:0] !== 3'b000) begin
            errors++; $display("FAIL abort_quiet got v=%b st=%h exp idle and empty", bus.valid, tnet_status); end
    endtask

    task automatic test_reset_mid_wait();
        tnet_cfg = '0; bus.ready = 1'b1;
        tnet_ctrl = 32'h0000_000F; tnet_addr = 16'h0042; axi_dt = 32'h0000_0099;
        tick(5);
        checks++; if (tnet_status[0] !== 1'b1) begin errors++; $display("FAIL rmw_busy got %b exp 1", tnet_status[0]); end
        tnet_ctrl = '0; bus.ready = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        checks++; if (bus.valid !== 1'b0 || bus.payload !== '0 || bus.src !== 1'b0 || tp_ack !== 1'b0) begin
            errors++; $display("FAIL rmw_outputs got v=%b p=%h src=%b ack=%b exp all 0", bus.valid, bus.payload, bus.src, tp_ack); end
        checks++; if (tnet_status !== 32'h0) begin errors++; $display("FAIL rmw_status got %h exp 0", tnet_status); end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tick(2);
        checks++; if (tnet_status !== 32'h0) begin errors++; $display("FAIL rmw_late_done got %h exp 0", tnet_status); end
    endtask

    initial begin
        test_reset();
        test_single_axi();
        test_contention();
        test_drop();
        test_timeout();
        test_backpressure_abort();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
